// File: rtl/offchip_sram_arb_pkg.sv
// Shared types and helpers for the off-chip SRAM round-robin arbiter.
package offchip_sram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] BAD_DATA_DEFAULT = 32'hBAD1BAD1;
    localparam int RR_MAX = 8;

    // Next active index after 'last', scanning last+1, last+2, ... mod nreq.
    // Iterating from the farthest candidate inward lets the nearest one win.
    function automatic int rr_pick(input logic [RR_MAX-1:0] active, input int last, input int nreq);
        rr_pick = last;
        for (int k = RR_MAX; k >= 1; k--) begin
            if (k <= nreq && active[3'((last + k) % nreq)]) begin
                rr_pick = (last + k) % nreq;
            end
        end
    endfunction

endpackage

// File: rtl/offchip_sram_arbiter_if.sv
// Requester-side and controller-side signals of the arbiter.
// master: the arbiter's view; slave: the requesters/controller environment.
interface offchip_sram_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]                 req_ren;
    logic [NREQ-1:0]                 req_wen;
    logic [NREQ-1:0][ADDR_W-1:0]     req_addr;
    logic [NREQ-1:0][DATA_W-1:0]     req_wdata;
    logic [NREQ-1:0][DATA_W/8-1:0]   req_byte_en;
    logic [NREQ-1:0][DATA_W-1:0]     req_rdata;
    logic [NREQ-1:0]                 req_wait;

    logic                            ren;
    logic                            wen;
    logic [ADDR_W-1:0]               addr;
    logic [DATA_W-1:0]               wdata;
    logic [DATA_W/8-1:0]             byte_en;
    logic [DATA_W-1:0]               rdata;
    logic                            sram_wait;

    modport master (
        input  req_ren, req_wen, req_addr, req_wdata, req_byte_en, rdata, sram_wait,
        output req_rdata, req_wait, ren, wen, addr, wdata, byte_en
    );

    modport slave (
        output req_ren, req_wen, req_addr, req_wdata, req_byte_en, rdata, sram_wait,
        input  req_rdata, req_wait, ren, wen, addr, wdata, byte_en
    );

endinterface

// File: rtl/offchip_sram_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first active requester after 'last'.
module rr_priority_picker
    import offchip_sram_arb_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  active,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [RR_MAX-1:0] active_ext;

    always_comb begin
        active_ext             = '0;
        active_ext[NREQ-1:0]   = active;
        pick                   = IDX_W'(rr_pick(active_ext, int'(last), NREQ));
        any                    = |active;
    end

endmodule

// File: rtl/offchip_sram_arbiter.sv
// Round-robin arbiter sharing one off-chip SRAM controller port between NREQ
// requesters; grants are held until the controller drops wait or a timeout.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate among active requesters, bus outputs zero
//   BUSY  | granted requester drives the controller until completion/timeout/drop
module offchip_sram_arbiter
    import offchip_sram_arb_pkg::*;
#(
    parameter int                NREQ     = 2,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] BAD_DATA = DATA_W'(BAD_DATA_DEFAULT)
) (
    input  logic                  CLK,
    input  logic                  RST,
    offchip_sram_arbiter_if.master bus,
    output logic                  timeout_err
);

    localparam int          IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] grant, grant_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [15:0]      tcnt, tcnt_nxt;

    logic [NREQ-1:0]  active;
    logic [IDX_W-1:0] pick;
    logic             any_active;
    logic             g_active;
    logic             g_done;
    logic             g_timeout;

    // A request with both ren and wen set is treated as a write.
    assign active = bus.req_ren | bus.req_wen;

    rr_priority_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .active (active),
        .last   (last),
        .pick   (pick),
        .any    (any_active)
    );

    always_comb begin
        g_active  = active[grant];
        g_done    = (state == BUSY) && g_active && !bus.sram_wait;
        g_timeout = (state == BUSY) && g_active && bus.sram_wait && (tcnt == TCNT_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            grant <= '0;
            last  <= IDX_W'(NREQ - 1);
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        tcnt_nxt  = tcnt;
        case (state)
            IDLE: begin
                if (any_active) begin
                    grant_nxt = pick;
                    tcnt_nxt  = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                tcnt_nxt = tcnt + 16'd1;
                // A dropped request leaves 'last' alone so the same requester keeps its turn.
                if (!g_active) begin
                    state_nxt = IDLE;
                end else if (g_done || g_timeout) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ren       = 1'b0;
        bus.wen       = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.byte_en   = '0;
        bus.req_wait  = active;
        bus.req_rdata = '0;
        timeout_err   = g_timeout;
        if (state == BUSY && g_active) begin
            bus.wen     = bus.req_wen[grant];
            bus.ren     = bus.req_ren[grant] & ~bus.req_wen[grant];
            bus.addr    = bus.req_addr[grant];
            bus.wdata   = bus.req_wdata[grant];
            bus.byte_en = bus.req_byte_en[grant];
        end
        if (g_done || g_timeout) begin
            bus.req_wait[grant]  = 1'b0;
            bus.req_rdata[grant] = g_done ? bus.rdata : BAD_DATA;
        end
    end

endmodule

// File: tb/tb_offchip_sram_arbiter.sv
// Directed, table-driven bench for offchip_sram_arbiter (NREQ=2, TIMEOUT=4).
module tb_offchip_sram_arbiter;

    localparam logic [31:0] A0  = 32'h0000_0010;
    localparam logic [31:0] W0  = 32'h1111_1111;
    localparam logic [3:0]  B0  = 4'hF;
    localparam logic [31:0] A1  = 32'h0000_0004;
    localparam logic [31:0] W1  = 32'hDEAD_BEEF;
    localparam logic [3:0]  B1  = 4'b1010;
    localparam logic [31:0] RD  = 32'hCAFE_F00D;
    localparam logic [31:0] RX  = 32'h1234_5678;
    localparam logic [31:0] BAD = 32'hBAD1_BAD1;
    localparam int          NV  = 36;

    typedef struct {
        logic        rst;
        logic [1:0]  ren;
        logic [1:0]  wen;
        logic        sw;
        logic [31:0] rdata;
        logic [1:0]  e_ctl;   // {ren, wen} seen by the controller
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [1:0]  e_wait;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic terr;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [NV];
    int   ndone, n0, n1, expect_g, last_cyc, gi;

    always #5 clk = ~clk;

    offchip_sram_arbiter_if #(.NREQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

    offchip_sram_arbiter #(
        .NREQ    (2),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .bus         (bus),
        .timeout_err (terr)
    );

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    // eg selects which requester's address/data the controller should see (-1 = none).
    function automatic vec_t mk(input logic r, input logic [1:0] rn, input logic [1:0] wn,
                                input logic sw, input logic [31:0] rd, input int eg,
                                input logic [1:0] ectl, input logic [1:0] ewait,
                                input logic [31:0] erd0, input logic [31:0] erd1, input logic eerr);
        vec_t v;
        v.rst     = r;
        v.ren     = rn;
        v.wen     = wn;
        v.sw      = sw;
        v.rdata   = rd;
        v.e_ctl   = ectl;
        v.e_addr  = (eg == 0) ? A0 : (eg == 1) ? A1 : 32'h0;
        v.e_wdata = (eg == 0) ? W0 : (eg == 1) ? W1 : 32'h0;
        v.e_be    = (eg == 0) ? B0 : (eg == 1) ? B1 : 4'h0;
        v.e_wait  = ewait;
        v.e_rd0   = erd0;
        v.e_rd1   = erd1;
        v.e_err   = eerr;
        return v;
    endfunction

    initial begin
        // single read, 2 stall cycles
        vecs[0]  = mk(0, 2'b00, 2'b00, 0, 0,  -1, 2'b00, 2'b00, 0,   0,  0);
        vecs[1]  = mk(0, 2'b01, 2'b00, 1, 0,  -1, 2'b00, 2'b01, 0,   0,  0);
        vecs[2]  = mk(0, 2'b01, 2'b00, 1, 0,   0, 2'b10, 2'b01, 0,   0,  0);
        vecs[3]  = mk(0, 2'b01, 2'b00, 1, 0,   0, 2'b10, 2'b01, 0,   0,  0);
        vecs[4]  = mk(0, 2'b01, 2'b00, 0, RD,  0, 2'b10, 2'b00, RD,  0,  0);
        vecs[5]  = mk(0, 2'b00, 2'b00, 0, 0,  -1, 2'b00, 2'b00, 0,   0,  0);
        // contention: both writing, alternate grants
        vecs[6]  = mk(1, 2'b00, 2'b00, 0, 0,  -1, 2'b00, 2'b00, 0,   0,  0);
        vecs[7]  = mk(0, 2'b00, 2'b11, 0, RX, -1, 2'b00, 2'b11, 0,   0,  0);
        vecs[8]  = mk(0, 2'b00, 2'b11, 0, RX,  0, 2'b01, 2'b10, RX,  0,  0);
        vecs[9]  = mk(0, 2'b00, 2'b11, 0, RX, -1, 2'b00, 2'b11, 0,   0,  0);
        vecs[10] = mk(0, 2'b00, 2'b11, 0, RX,  1, 2'b01, 2'b01, 0,   RX, 0);
        vecs[11] = mk(0, 2'b00, 2'b11, 0, RX, -1, 2'b00, 2'b11, 0,   0,  0);
        vecs[12] = mk(0, 2'b00, 2'b11, 0, RX,  0, 2'b01, 2'b10, RX,  0,  0);
        vecs[13] = mk(0, 2'b00, 2'b11, 0, RX, -1, 2'b00, 2'b11, 0,   0,  0);
        // requester 1 with ren and wen both set -> write
        vecs[14] = mk(0, 2'b10, 2'b11, 0, RX,  1, 2'b01, 2'b01, 0,   RX, 0);
        vecs[15] = mk(0, 2'b00, 2'b00, 0, 0,  -1, 2'b00, 2'b00, 0,   0,  0);
        // timeout after 4 BUSY cycles, then forced-idle cycle
        vecs[16] = mk(0, 2'b01, 2'b00, 1, RX, -1, 2'b00, 2'b01, 0,   0,  0);
        vecs[17] = mk(0, 2'b01, 2'b00, 1, RX,  0, 2'b10, 2'b01, 0,   0,  0);
        vecs[18] = mk(0, 2'b01, 2'b00, 1, RX,  0, 2'b10, 2'b01, 0,   0,  0);
        vecs[19] = mk(0, 2'b01, 2'b00, 1, RX,  0, 2'b10, 2'b01, 0,   0,  0);
        vecs[20] = mk(0, 2'b01, 2'b00, 1, RX,  0, 2'b10, 2'b00, BAD, 0,  1);
        vecs[21] = mk(0, 2'b01, 2'b00, 1, RX, -1, 2'b00, 2'b01, 0,   0,  0);
        vecs[22] = mk(0, 2'b01, 2'b00, 0, RX,  0, 2'b10, 2'b00, RX,  0,  0);
        vecs[23] = mk(0, 2'b00, 2'b00, 0, 0,  -1, 2'b00, 2'b00, 0,   0,  0);
        // dropped request keeps requester 0's turn
        vecs[24] = mk(1, 2'b00, 2'b00, 0, 0,  -1, 2'b00, 2'b00, 0,   0,  0);
        vecs[25] = mk(0, 2'b01, 2'b00, 1, 0,  -1, 2'b00, 2'b01, 0,   0,  0);
        vecs[26] = mk(0, 2'b01, 2'b00, 1, 0,   0, 2'b10, 2'b01, 0,   0,  0);
        vecs[27] = mk(0, 2'b00, 2'b00, 1, 0,  -1, 2'b00, 2'b00, 0,   0,  0);
        vecs[28] = mk(0, 2'b11, 2'b00, 1, RX, -1, 2'b00, 2'b11, 0,   0,  0);
        vecs[29] = mk(0, 2'b11, 2'b00, 0, RX,  0, 2'b10, 2'b10, RX,  0,  0);
        // reset mid-BUSY, then requester 0 wins first
        vecs[30] = mk(0, 2'b10, 2'b00, 1, RX, -1, 2'b00, 2'b10, 0,   0,  0);
        vecs[31] = mk(0, 2'b10, 2'b00, 1, RX,  1, 2'b10, 2'b10, 0,   0,  0);
        vecs[32] = mk(1, 2'b10, 2'b00, 1, RX,  1, 2'b10, 2'b10, 0,   0,  0);
        vecs[33] = mk(0, 2'b11, 2'b00, 1, RX, -1, 2'b00, 2'b11, 0,   0,  0);
        vecs[34] = mk(0, 2'b11, 2'b00, 0, RX,  0, 2'b10, 2'b10, RX,  0,  0);
        vecs[35] = mk(0, 2'b00, 2'b00, 0, 0,  -1, 2'b00, 2'b00, 0,   0,  0);

        rst                  = 1'b1;
        bus.req_ren          = '0;
        bus.req_wen          = '0;
        bus.req_addr[0]      = A0;
        bus.req_addr[1]      = A1;
        bus.req_wdata[0]     = W0;
        bus.req_wdata[1]     = W1;
        bus.req_byte_en[0]   = B0;
        bus.req_byte_en[1]   = B1;
        bus.rdata            = '0;
        bus.sram_wait        = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rst           = vecs[i].rst;
            bus.req_ren   = vecs[i].ren;
            bus.req_wen   = vecs[i].wen;
            bus.sram_wait = vecs[i].sw;
            bus.rdata     = vecs[i].rdata;
            @(negedge clk);
            chk("ctl_ren_wen", i, 32'({bus.ren, bus.wen}), 32'(vecs[i].e_ctl));
            chk("ctl_addr",    i, bus.addr,                vecs[i].e_addr);
            chk("ctl_wdata",   i, bus.wdata,               vecs[i].e_wdata);
            chk("ctl_byte_en", i, 32'(bus.byte_en),        32'(vecs[i].e_be));
            chk("req_wait",    i, 32'(bus.req_wait),       32'(vecs[i].e_wait));
            chk("req_rdata0",  i, bus.req_rdata[0],        vecs[i].e_rd0);
            chk("req_rdata1",  i, bus.req_rdata[1],        vecs[i].e_rd1);
            chk("timeout_err", i, 32'(terr),               32'(vecs[i].e_err));
            @(posedge clk);
            #1;
        end

        // Fairness: both requesters write continuously, 16 cycles after reset.
        rst           = 1'b1;
        bus.req_ren   = 2'b00;
        bus.req_wen   = 2'b00;
        bus.sram_wait = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.req_wen = 2'b11;
        ndone    = 0;
        n0       = 0;
        n1       = 0;
        expect_g = 0;
        last_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.req_wait != 2'b11) begin
                gi = (bus.req_wait == 2'b10) ? 0 : (bus.req_wait == 2'b01) ? 1 : 9;
                chk("fair_grant_order", 100 + c, 32'(gi), 32'(expect_g));
                if (last_cyc >= 0) chk("fair_spacing", 100 + c, 32'(c - last_cyc), 32'd2);
                if (gi == 0) n0++;
                if (gi == 1) n1++;
                expect_g = 1 - expect_g;
                last_cyc = c;
                ndone++;
            end
            @(posedge clk);
            #1;
        end
        chk("fair_completions", 200, 32'(ndone), 32'd8);
        chk("fair_count_req0",  201, 32'(n0),    32'd4);
        chk("fair_count_req1",  202, 32'(n1),    32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
